// File: rtl/ipm2l_fifo_fwft_rd_pkg.sv
// Shared constants and helpers for the ipm2l FIFO first-word-fall-through read path.
package ipm2l_fifo_fwft_rd_pkg;

  localparam int unsigned c_CNT_W          = 2;
  localparam int unsigned c_RD_LATENCY_MIN = 1;
  localparam int unsigned c_RD_LATENCY_MAX = 2;

  function automatic bit rd_latency_ok(input int unsigned lat);
    return (lat >= c_RD_LATENCY_MIN) && (lat <= c_RD_LATENCY_MAX);
  endfunction

  // Circular pointer increment, wrapping at depth-1 back to 0.
  function automatic logic [c_CNT_W-1:0] ptr_inc(input logic [c_CNT_W-1:0] ptr,
                                                 input int unsigned       depth);
    return (32'(ptr) == depth - 1) ? '0 : ptr + c_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ipm2l_fifo_fwft_rd_if.sv
// FIFO read port plus output stream of the FWFT read adapter.
interface ipm2l_fifo_fwft_rd_if
  import ipm2l_fifo_fwft_rd_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH = 32
);

  logic                    fifo_rempty;
  logic                    fifo_r_en;
  logic [c_DATA_WIDTH-1:0] fifo_rdata;
  logic [c_DATA_WIDTH-1:0] m_tdata;
  logic                    m_tvalid;
  logic                    m_tready;
  logic [c_CNT_W-1:0]      buf_level;

  modport master (
    input  fifo_rempty, fifo_rdata, m_tready,
    output fifo_r_en, m_tdata, m_tvalid, buf_level
  );

  modport slave (
    output fifo_rempty, fifo_rdata, m_tready,
    input  fifo_r_en, m_tdata, m_tvalid, buf_level
  );

endinterface

// File: rtl/ipm2l_fifo_skid_buf.sv
// Circular output buffer: lands read data, presents the head word as a registered-valid stream.
module ipm2l_fifo_skid_buf
  import ipm2l_fifo_fwft_rd_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH = 32,
  parameter int unsigned c_BUF_DEPTH  = 2
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    land,
  input  logic [c_DATA_WIDTH-1:0] land_data,
  input  logic                    ready,
  output logic [c_DATA_WIDTH-1:0] data,
  output logic                    valid,
  output logic [c_CNT_W-1:0]      level
);

  // Storage is sized to the pointer range so every pointer value indexes a real entry.
  localparam int unsigned c_MEM_N = 1 << c_CNT_W;

  logic [c_DATA_WIDTH-1:0] mem [c_MEM_N];
  logic [c_CNT_W-1:0]      wr_ptr;
  logic [c_CNT_W-1:0]      rd_ptr;
  logic [c_CNT_W-1:0]      occ;
  logic [c_CNT_W-1:0]      occ_nxt_c;
  logic                    pop_c;

  assign pop_c = valid & ready;
  assign data  = mem[rd_ptr];
  assign level = occ;

  always_comb begin
    occ_nxt_c = occ;
    unique case ({land, pop_c})
      2'b10:   occ_nxt_c = occ + c_CNT_W'(1);
      2'b01:   occ_nxt_c = occ - c_CNT_W'(1);
      default: occ_nxt_c = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      valid  <= 1'b0;
    end else begin
      if (land) begin
        mem[wr_ptr] <= land_data;
        wr_ptr      <= ptr_inc(wr_ptr, c_BUF_DEPTH);
      end
      if (pop_c) begin
        rd_ptr <= ptr_inc(rd_ptr, c_BUF_DEPTH);
      end
      occ   <= occ_nxt_c;
      valid <= (occ_nxt_c != '0);
    end
  end

  // The credit rule upstream guarantees a free entry for every landing word.
  a_no_land_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    land |-> (32'(occ) < c_BUF_DEPTH));

endmodule

// File: rtl/ipm2l_fifo_fwft_rd.sv
// FWFT read adapter: issues FIFO reads against buffer credit and hides the DRM read latency.
module ipm2l_fifo_fwft_rd
  import ipm2l_fifo_fwft_rd_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH = 32,
  parameter int unsigned c_RD_LATENCY = 1
)(
  input  logic                   rclk,
  input  logic                   rrst_n,
  ipm2l_fifo_fwft_rd_if.master   bus
);

  localparam int unsigned c_BUF_DEPTH = c_RD_LATENCY + 1;
  localparam int unsigned c_SUM_W     = c_CNT_W + 1;
  localparam bit          c_LAT_OK    = rd_latency_ok(c_RD_LATENCY);

  logic [c_RD_LATENCY-1:0] pipe;
  logic [c_CNT_W-1:0]      inflight_c;
  logic [c_CNT_W-1:0]      occ;
  logic [c_SUM_W-1:0]      committed_c;
  logic                    accept_c;
  logic                    pop_c;
  logic                    land_c;

  assign accept_c   = bus.fifo_r_en & ~bus.fifo_rempty;
  assign pop_c      = bus.m_tvalid & bus.m_tready;
  assign land_c     = pipe[c_RD_LATENCY-1];
  assign inflight_c = c_CNT_W'($countones(pipe));

  // Words already owned by the buffer, less the one leaving this cycle; m_tready feeds r_en directly.
  assign committed_c   = c_SUM_W'(occ) + c_SUM_W'(inflight_c) - c_SUM_W'(pop_c);
  assign bus.fifo_r_en = rrst_n & ~bus.fifo_rempty & (committed_c < c_SUM_W'(c_BUF_DEPTH));

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      pipe <= '0;
    end else begin
      pipe <= c_RD_LATENCY'({pipe, accept_c});
    end
  end

  ipm2l_fifo_skid_buf #(
    .c_DATA_WIDTH (c_DATA_WIDTH),
    .c_BUF_DEPTH  (c_BUF_DEPTH)
  ) u_skid_buf (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .land      (land_c),
    .land_data (bus.fifo_rdata),
    .ready     (bus.m_tready),
    .data      (bus.m_tdata),
    .valid     (bus.m_tvalid),
    .level     (occ)
  );

  assign bus.buf_level = occ;

  a_rd_latency_legal: assert property (@(posedge rclk) c_LAT_OK);

  a_credit_bound: assert property (@(posedge rclk) disable iff (!rrst_n)
    (32'(occ) + 32'(inflight_c)) <= c_BUF_DEPTH);

endmodule
